// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light controller: interval codes, lamp
// patterns, the phase enum and the per-phase output decode.
package traffic_pkg;

  localparam logic [1:0] T_BASE = 2'b00;
  localparam logic [1:0] T_EXT  = 2'b01;
  localparam logic [1:0] T_YEL  = 2'b10;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [2:0] {
    S_MG1    = 3'd0,
    S_MG_EXT = 3'd1,
    S_MY     = 3'd2,
    S_WALK   = 3'd3,
    S_SG     = 3'd4,
    S_SG_EXT = 3'd5,
    S_SY     = 3'd6
  } state_t;

  typedef struct packed {
    logic [2:0] main_l;
    logic [2:0] side_l;
    logic [1:0] interval;
    logic       walk;
  } lamp_t;

  function automatic lamp_t decode_state(input state_t s);
    lamp_t o;
    o = '{main_l: LAMP_G, side_l: LAMP_R, interval: T_BASE, walk: 1'b0};
    case (s)
      S_MG1:    o = '{main_l: LAMP_G, side_l: LAMP_R, interval: T_BASE, walk: 1'b0};
      S_MG_EXT: o = '{main_l: LAMP_G, side_l: LAMP_R, interval: T_EXT,  walk: 1'b0};
      S_MY:     o = '{main_l: LAMP_Y, side_l: LAMP_R, interval: T_YEL,  walk: 1'b0};
      S_WALK:   o = '{main_l: LAMP_R, side_l: LAMP_R, interval: T_EXT,  walk: 1'b1};
      S_SG:     o = '{main_l: LAMP_R, side_l: LAMP_G, interval: T_BASE, walk: 1'b0};
      S_SG_EXT: o = '{main_l: LAMP_R, side_l: LAMP_G, interval: T_EXT,  walk: 1'b0};
      S_SY:     o = '{main_l: LAMP_R, side_l: LAMP_Y, interval: T_YEL,  walk: 1'b0};
      default:  o = '{main_l: LAMP_G, side_l: LAMP_R, interval: T_BASE, walk: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/interval_timer.sv
// Phase timer: waits for the interval lookup, loads the seconds value, counts
// it down on one_hz_enable. Handshake: a one-cycle start restarts the load
// sequence; expired is a one-cycle pulse after the count goes 1 -> 0.
module interval_timer #(
  parameter int LOOKUP_LAT = 1
) (
  input  logic       clk,
  input  logic       global_reset_n,
  input  logic       start,
  input  logic [3:0] value,
  input  logic       one_hz_enable,
  output logic       expired
);

  // Out of reset the first edge also consumes one delay step.
  localparam logic [2:0] RST_DLY   = 3'(LOOKUP_LAT + 1);
  localparam logic [2:0] START_DLY = 3'(LOOKUP_LAT);

  logic       pend_q, pend_d;
  logic       run_q, run_d;
  logic       exp_q, exp_d;
  logic [2:0] dly_q, dly_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      pend_q <= 1'b1;
      run_q  <= 1'b0;
      exp_q  <= 1'b0;
      dly_q  <= RST_DLY;
      cnt_q  <= 4'd0;
    end else begin
      pend_q <= pend_d;
      run_q  <= run_d;
      exp_q  <= exp_d;
      dly_q  <= dly_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    pend_d = pend_q;
    run_d  = run_q;
    exp_d  = 1'b0;
    dly_d  = dly_q;
    cnt_d  = cnt_q;
    if (start) begin
      pend_d = 1'b1;
      run_d  = 1'b0;
      dly_d  = START_DLY;
    end else if (pend_q) begin
      // Seconds pulses before (and at) the load edge are deliberately dropped.
      if (dly_q <= 3'd1) begin
        pend_d = 1'b0;
        run_d  = 1'b1;
        cnt_d  = (value == 4'd0) ? 4'd1 : value;
      end else begin
        dly_d = dly_q - 3'd1;
      end
    end else if (run_q && one_hz_enable) begin
      if (cnt_q <= 4'd1) begin
        run_d = 1'b0;
        cnt_d = 4'd0;
        exp_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  assign expired = exp_q;

endmodule

// File: rtl/traffic_light_fsm.sv
// Main/side-street sequencer: walks the green/yellow/walk phases, requests the
// interval for each phase and drives registered lamp outputs.
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int LOOKUP_LAT = 1
) (
  input  logic       clk,
  input  logic       global_reset_n,
  input  logic       one_hz_enable,
  input  logic [3:0] output_time_value,
  input  logic       sensor,
  input  logic       walk_request,
  input  logic       reprogram,
  output logic [1:0] fsm_requested_interval,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk_lamp,
  output logic       walk_reset,
  output state_t     state_o
);

  state_t state_q, state_d;
  lamp_t  out_q, out_d;
  logic   walk_reset_q, walk_reset_d;
  logic   expired;
  logic   restart;

  assign restart = reprogram | expired;

  interval_timer #(.LOOKUP_LAT(LOOKUP_LAT)) u_timer (
    .clk            (clk),
    .global_reset_n (global_reset_n),
    .start          (restart),
    .value          (output_time_value),
    .one_hz_enable  (one_hz_enable),
    .expired        (expired)
  );

  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q      <= S_MG1;
      out_q        <= '{main_l: LAMP_G, side_l: LAMP_R, interval: T_BASE, walk: 1'b0};
      walk_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      walk_reset_q <= walk_reset_d;
    end
  end

  // Reprogram has priority over an expiry arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    if (reprogram) begin
      state_d = S_MG1;
    end else if (expired) begin
      case (state_q)
        S_MG1:    state_d = sensor ? S_MY : S_MG_EXT;
        S_MG_EXT: state_d = S_MY;
        S_MY:     state_d = walk_request ? S_WALK : S_SG;
        S_WALK:   state_d = S_SG;
        S_SG:     state_d = sensor ? S_SG_EXT : S_SY;
        S_SG_EXT: state_d = S_SY;
        S_SY:     state_d = S_MG1;
        default:  state_d = S_MG1;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register with it.
  always_comb begin
    out_d        = decode_state(state_d);
    walk_reset_d = (state_d == S_WALK) && (state_q != S_WALK);
  end

  assign fsm_requested_interval = out_q.interval;
  assign main_lights            = out_q.main_l;
  assign side_lights            = out_q.side_l;
  assign walk_lamp              = out_q.walk;
  assign walk_reset             = walk_reset_q;
  assign state_o                = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: phase-level reference model driven by the
// same stimulus, checked every cycle with immediate assertions.
module tb_traffic_light_fsm;
  import traffic_pkg::*;

  localparam int LAT = 1;
  localparam int P_MG1 = 0, P_MG_EXT = 1, P_MY = 2, P_WALK = 3, P_SG = 4, P_SG_EXT = 5, P_SY = 6;

  logic       clk = 1'b0;
  logic       global_reset_n = 1'b0;
  logic       one_hz_enable = 1'b0;
  logic [3:0] output_time_value;
  logic       sensor = 1'b0;
  logic       walk_request = 1'b0;
  logic       reprogram = 1'b0;
  logic [1:0] fsm_requested_interval;
  logic [2:0] main_lights, side_lights;
  logic       walk_lamp, walk_reset;
  state_t     dbg_state;

  int errors = 0;
  int checks = 0;

  // Time-parameter store: seconds per interval code.
  logic [3:0] t_base = 4'd6, t_ext = 4'd3, t_yel = 4'd2;

  always_comb begin
    case (fsm_requested_interval)
      2'b00:   output_time_value = t_base;
      2'b01:   output_time_value = t_ext;
      2'b10:   output_time_value = t_yel;
      default: output_time_value = 4'd0;
    endcase
  end

  traffic_light_fsm #(.LOOKUP_LAT(LAT)) dut (
    .clk                    (clk),
    .global_reset_n         (global_reset_n),
    .one_hz_enable          (one_hz_enable),
    .output_time_value      (output_time_value),
    .sensor                 (sensor),
    .walk_request           (walk_request),
    .reprogram              (reprogram),
    .fsm_requested_interval (fsm_requested_interval),
    .main_lights            (main_lights),
    .side_lights            (side_lights),
    .walk_lamp              (walk_lamp),
    .walk_reset             (walk_reset),
    .state_o                (dbg_state)
  );

  always #5 clk = ~clk;

  // Per-phase expected outputs.
  logic [2:0] ph_main [7] = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ph_side [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};
  logic [1:0] ph_int  [7] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b01, 2'b10};
  logic       ph_walk [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  // Reference model state.
  int   k = 0;          // posedge index since time zero (counted by step)
  int   ph = P_MG1;     // current phase
  int   entry = 1;      // edge index at which the phase started
  int   cnt = 0;        // seconds counted in this phase
  logic exp_flag = 1'b0;
  logic exp_wr = 1'b0;
  int   hz_cnt = 0;

  function automatic int next_phase(input int p, input logic s, input logic w);
    case (p)
      P_MG1:    return s ? P_MY : P_MG_EXT;
      P_MG_EXT: return P_MY;
      P_MY:     return w ? P_WALK : P_SG;
      P_WALK:   return P_SG;
      P_SG:     return s ? P_SG_EXT : P_SY;
      P_SG_EXT: return P_SY;
      default:  return P_MG1;
    endcase
  endfunction

  function automatic int secs(input int p);
    logic [3:0] v;
    case (ph_int[p])
      2'b00:   v = t_base;
      2'b01:   v = t_ext;
      default: v = t_yel;
    endcase
    return (v == 4'd0) ? 1 : int'(v);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, expv);
    end
  endtask

  task automatic check_outputs();
    chk("main_lights", 8'(main_lights), 8'(ph_main[ph]));
    chk("side_lights", 8'(side_lights), 8'(ph_side[ph]));
    chk("interval", 8'(fsm_requested_interval), 8'(ph_int[ph]));
    chk("walk_lamp", 8'(walk_lamp), 8'(ph_walk[ph]));
    chk("walk_reset", 8'(walk_reset), 8'(exp_wr));
  endtask

  task automatic model_reset();
    ph = P_MG1; entry = k + 1; cnt = 0; exp_flag = 1'b0; exp_wr = 1'b0;
  endtask

  task automatic model_edge();
    k++;
    exp_wr = 1'b0;
    if (reprogram) begin
      ph = P_MG1; entry = k; cnt = 0; exp_flag = 1'b0;
    end else if (exp_flag) begin
      ph = next_phase(ph, sensor, walk_request);
      entry = k; cnt = 0; exp_flag = 1'b0;
      exp_wr = (ph == P_WALK);
    end else if (k > entry + LAT && one_hz_enable) begin
      cnt++;
      if (cnt >= secs(ph)) exp_flag = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (walk_reset) walk_request = 1'b0;
    one_hz_enable = (hz_cnt == 9);
    hz_cnt = (hz_cnt == 9) ? 0 : hz_cnt + 1;
    @(posedge clk);
    #1;
    model_edge();
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input string tag, input int target, input int max_cycles);
    for (int i = 0; i < max_cycles && ph != target; i++) step();
    chk(tag, 8'(ph), 8'(target));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_main"}, 8'(main_lights), 8'(3'b001));
    chk({tag, "_side"}, 8'(side_lights), 8'(3'b100));
    chk({tag, "_int"}, 8'(fsm_requested_interval), 8'(2'b00));
    chk({tag, "_walk"}, 8'(walk_lamp), 8'(1'b0));
    chk({tag, "_wrst"}, 8'(walk_reset), 8'(1'b0));
  endtask

  initial begin
    // Reset held for a few edges, checked, released between edges.
    repeat (3) @(posedge clk);
    k = 3;
    #1;
    check_reset_values("reset");
    #1;
    global_reset_n = 1'b1;
    model_reset();

    // Base cycle: no sensor, no walk.
    sensor = 1'b0; walk_request = 1'b0;
    run(420);

    // Sensor high throughout.
    sensor = 1'b1;
    run(400);
    sensor = 1'b0;

    // Walk request raised during MG1.
    run_until("reach_mg1_walk", P_MG1, 300);
    run(5);
    walk_request = 1'b1;
    run_until("reach_walk", P_WALK, 300);
    run(60);

    // Reprogram mid-SG.
    run_until("reach_sg", P_SG, 300);
    run(15);
    reprogram = 1'b1;
    step();
    reprogram = 1'b0;
    chk("reprog_to_mg1", 8'(ph), 8'(P_MG1));
    run(120);

    // Reprogram coincident with an expiry pulse.
    begin
      int guard = 0;
      while (!(hz_cnt == 9 && !exp_flag && (k + 1) > entry + LAT && cnt == secs(ph) - 1
               && ph != P_MG1) && guard < 400) begin
        step();
        guard++;
      end
      chk("expiry_window_found", 8'(guard < 400), 8'(1));
    end
    reprogram = 1'b1;
    step();
    reprogram = 1'b0;
    chk("reprog_beats_expiry", 8'(ph), 8'(P_MG1));
    run(80);

    // Zero yellow interval: MY and SY last a single second.
    t_yel = 4'd0;
    run(450);
    run_until("reach_sg_restore", P_SG, 300);
    t_yel = 4'd2;

    // Randomised inputs with occasional reprogram.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 49) == 0) sensor = ~sensor;
      if ($urandom_range(0, 79) == 0) walk_request = 1'b1;
      reprogram = ($urandom_range(0, 399) == 0);
      step();
      reprogram = 1'b0;
    end
    sensor = 1'b0;

    // Reset asserted mid-MY, between edges.
    run_until("reach_my_reset", P_MY, 400);
    run(4);
    #1;
    global_reset_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    #1;
    global_reset_n = 1'b1;
    run(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Main/side-street sequencing controller for the traffic-light design. Each phase, it drives `fsm_requested_interval` to the time-parameter store and loads the returned `output_time_value` into an internal seconds countdown. When the countdown expires it advances through green/yellow/walk phases, using the side-street sensor and the latched walk request to decide which phases to run. It drives the lamp outputs and clears the external walk register.

## Interface
- `LOOKUP_LAT`, default 1: cycles after `fsm_requested_interval` changes before `output_time_value` is valid (legal range 0–3).
- `clk`  in  1  system clock.
- `global_reset_n`  in  1  asynchronous, active-low reset.
- `one_hz_enable`  in  1  single-cycle pulse, once per second, from the divider.
- `output_time_value`  in  4  seconds for the currently requested interval.
- `sensor`  in  1  side-street vehicle present (already synchronized).
- `walk_request`  in  1  latched pedestrian request (held until `walk_reset`).
- `reprogram`  in  1  synchronized single-cycle pulse; forces a restart.
- `fsm_requested_interval`  out  2  interval codes: 00 tBASE, 01 tEXT, 10 tYEL.
- `main_lights`  out  3  {R,Y,G} for the main street, one-hot.
- `side_lights`  out  3  {R,Y,G} for the side street, one-hot.
- `walk_lamp`  out  1  pedestrian walk lamp.
- `walk_reset`  out  1  single-cycle pulse that clears the walk register.

## Operation
Each state lists its lamps, its interval, and the transition taken when the timer expires:
- **MG1**: main G, side R, tBASE. Expiry → MY if `sensor`, else MG_EXT.
- **MG_EXT**: main G, side R, tEXT. Expiry → MY.
- **MY**: main Y, side R, tYEL. Expiry → WALK if `walk_request`, else SG.
- **WALK**: both R, `walk_lamp`=1, tEXT. `walk_reset` pulses on the entry cycle. Expiry → SG.
- **SG**: main R, side G, tBASE. Expiry → SG_EXT if `sensor`, else SY.
- **SG_EXT**: main R, side G, tEXT. Expiry → SY.
- **SY**: main R, side Y, tYEL. Expiry → MG1.

Input sampling and outputs:
- `sensor` and `walk_request` are sampled only in the expiry cycle.
- All outputs are registered and decoded from the state register.

Timer:
- On state entry, the timer waits LOOKUP_LAT cycles, then loads `output_time_value`.
- After loading, it decrements on each `one_hz_enable`. It expires on the pulse that takes the count from 1 to 0.
- A loaded value of 0 is treated as 1.
- `one_hz_enable` pulses that arrive before the load are ignored.

Reprogram:
- A `reprogram` pulse forces MG1 and restarts the load sequence, from any state.
- `reprogram` wins over a simultaneous expiry.

## Timing
Reset values, applied immediately and asynchronously:
- state MG1
- `fsm_requested_interval`=00
- `main_lights`=001
- `side_lights`=100
- `walk_lamp`=0
- `walk_reset`=0
- timer idle, with a load pending

After reset release, the load occurs LOOKUP_LAT cycles after the first clock edge.

Transition cycle:
- Expiry is detected at edge E.
- At edge E+1, the new state, `fsm_requested_interval`, lamps and `walk_reset` all update together.
- The load happens at edge E+1+LOOKUP_LAT.

Phase duration is the loaded value (minimum 1) × one second, plus at most LOOKUP_LAT+2 clock cycles.

`walk_reset` is high for exactly one cycle per WALK entry and never high outside the WALK entry cycle.

Reset asserted mid-phase aborts the phase. No partial countdown survives reset.

## Structure
Package `traffic_pkg` holds:
- the interval codes (T_BASE, T_EXT, T_YEL);
- the lamp encodings (LAMP_R=100, LAMP_Y=010, LAMP_G=001);
- the state enum.

Sub-module `interval_timer` contains the load-latency delay, the 4-bit down-counter and the expiry pulse. Its ports are: `clk`, `global_reset_n`, `start`, `value`, `one_hz_enable`, `expired`.

## Test plan
The bench models the time-parameter store with tBASE=6, tEXT=3, tYEL=2, LOOKUP_LAT=1, and `one_hz_enable` every 10 cycles.
- **Base cycle.** `sensor`=0, `walk_request`=0 → MG1 6 s, MG_EXT 3 s, MY 2 s, SG 6 s, SY 2 s, then MG1 again. `fsm_requested_interval` sequence is 00,01,10,00,10.
- **Sensor high.** `sensor`=1 throughout → MG1 goes straight to MY. SG is followed by SG_EXT (3 s), then SY.
- **Walk request.** `walk_request`=1 set during MG1 → after MY, WALK with both R and `walk_lamp`=1 for 3 s. `walk_reset` is a single-cycle pulse on the WALK entry cycle. Next state is SG.
- **Reprogram.** `reprogram` pulse mid-SG → next cycle shows MG1, main G, interval 00. A fresh 6 s countdown follows. Also apply `reprogram` in the same cycle as an expiry and confirm MG1 wins.
- **Zero value.** `output_time_value`=0 for tYEL → MY and SY each last exactly one `one_hz_enable` pulse.
- **Reset mid-phase.** `global_reset_n` driven low mid-MY, between clock edges → outputs go to their reset values before the next edge. After release, MG1 runs a full 6 s.
